mem_access_ctrl: RTL and testbench

//  Sequences every memory transaction through MAR/MBR for two requesters: instruction fetch and data load/store.

---
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory transaction sequencer: round-robin arbitration between fetch and data
// requesters, then a MAR/MBR handshake with memory bounded by a ready timeout.
module mem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              mem_ready,
  output logic              fetch_gnt,
  output logic              data_gnt,
  output logic              fetch_done,
  output logic              data_done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_load,
  output logic              mbr_ld_acc,
  output logic              mbr_ld_mem,
  output logic              mem_rd,
  output logic              mem_wr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_FINISH, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last_owner, last_owner_nxt;
  logic              we, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              pick_fetch, pick_data;

  // On a tie the requester that did not win last time is served
  assign pick_fetch = fetch_req && (!data_req  || last_owner == OWN_DATA);
  assign pick_data  = data_req  && (!fetch_req || last_owner == OWN_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_DATA;
      last_owner <= OWN_DATA;
      we         <= 1'b0;
      mar_addr   <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      we         <= we_nxt;
      mar_addr   <= addr_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    we_nxt         = we;
    addr_nxt       = mar_addr;
    cnt_nxt        = cnt;
    fetch_gnt      = 1'b0;
    data_gnt       = 1'b0;
    fetch_done     = 1'b0;
    data_done      = 1'b0;
    err            = 1'b0;
    busy           = (state != S_IDLE);
    mar_load       = 1'b0;
    mbr_ld_acc     = 1'b0;
    mbr_ld_mem     = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_fetch) begin
          owner_nxt      = OWN_FETCH;
          last_owner_nxt = OWN_FETCH;
          we_nxt         = 1'b0;
          addr_nxt       = fetch_addr;
          state_nxt      = S_SETUP;
        end else if (pick_data) begin
          owner_nxt      = OWN_DATA;
          last_owner_nxt = OWN_DATA;
          we_nxt         = data_we;
          addr_nxt       = data_addr;
          state_nxt      = S_SETUP;
        end
      end
      S_SETUP: begin
        fetch_gnt  = (owner == OWN_FETCH);
        data_gnt   = (owner == OWN_DATA);
        mar_load   = 1'b1;
        mbr_ld_acc = we;
        cnt_nxt    = '0;
        state_nxt  = S_ACCESS;
      end
      S_ACCESS: begin
        mem_wr = we;
        mem_rd = !we;
        // A ready arriving in the last allowed cycle still completes
        if (mem_ready)                       state_nxt = we ? S_FINISH : S_CAPTURE;
        else if (cnt == CW'(TIMEOUT - 1))    state_nxt = S_ERR;
        else                                 cnt_nxt   = cnt + CW'(1);
      end
      S_CAPTURE: begin
        mbr_ld_mem = 1'b1;
        state_nxt  = S_FINISH;
      end
      S_FINISH: begin
        fetch_done = (owner == OWN_FETCH);
        data_done  = (owner == OWN_DATA);
        state_nxt  = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: cycle-exact directed checks plus a grant/completion
// scoreboard fed with the transaction each stimulus step is expected to produce.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 8;

  logic clk, rst;
  logic fetch_req, data_req, data_we, mem_ready;
  logic [ADDR_W-1:0] fetch_addr, data_addr, mar_addr;
  logic fetch_gnt, data_gnt, fetch_done, data_done, err, busy;
  logic mar_load, mbr_ld_acc, mbr_ld_mem, mem_rd, mem_wr;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .mem_ready(mem_ready),
    .fetch_gnt(fetch_gnt), .data_gnt(data_gnt),
    .fetch_done(fetch_done), .data_done(data_done),
    .err(err), .busy(busy), .mar_addr(mar_addr), .mar_load(mar_load),
    .mbr_ld_acc(mbr_ld_acc), .mbr_ld_mem(mbr_ld_mem),
    .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  typedef struct {
    logic             own;   // 0 fetch, 1 data
    logic             we;
    logic [ADDR_W-1:0] addr;
    logic             to;    // expected to time out
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic inflight;
  int n_tests, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic own, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic to);
    exp_t e;
    e.own = own; e.we = we; e.addr = addr; e.to = to;
    return e;
  endfunction

  function automatic logic [19:0] all_outs();
    return {fetch_gnt, data_gnt, fetch_done, data_done, err, busy, mar_load,
            mbr_ld_acc, mbr_ld_mem, mem_rd, mem_wr, mar_addr};
  endfunction

  // Scoreboard: grants pop the expected transaction, completions close it
  always @(negedge clk) begin
    chk("excl_mbr", {31'd0, mbr_ld_acc & mbr_ld_mem}, 0);
    chk("excl_mem", {31'd0, mem_rd & mem_wr}, 0);
    if (rst) inflight = 1'b0;
    else begin
      if (fetch_gnt || data_gnt) begin
        if (exp_q.size() == 0) chk("sb_unexpected_gnt", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("sb_owner", {31'd0, data_gnt}, {31'd0, cur.own});
          chk("sb_addr", {24'd0, mar_addr}, {24'd0, cur.addr});
          chk("sb_acc", {31'd0, mbr_ld_acc}, {31'd0, cur.we});
          inflight = 1'b1;
        end
      end
      if (fetch_done || data_done || err) begin
        if (!inflight) chk("sb_orphan_done", 1, 0);
        else chk("sb_kind", {29'd0, err, data_done, fetch_done},
                 cur.to ? 32'd4 : (cur.own ? 32'd2 : 32'd1));
        inflight = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done, n_rd, n_err;
    n_tests = 0; n_fail = 0; inflight = 1'b0;

    // 1: reset with both requests high, fetch wins first tie
    rst = 1; fetch_req = 1; data_req = 1; data_we = 0; mem_ready = 0;
    fetch_addr = 8'h55; data_addr = 8'h66;
    exp_q.push_back(mk(0, 0, 8'h55, 0));
    tick(); chk("rst_outs_c1", all_outs(), 0);
    tick(); chk("rst_outs_c2", all_outs(), 0);
    rst = 0;
    tick(); chk("t1_gnt", {fetch_gnt, data_gnt, mar_load}, 3'b101);
    chk("t1_addr", mar_addr, 8'h55);
    fetch_req = 0; data_req = 0; mem_ready = 1;
    tick(); chk("t1_rd", {mem_rd, mem_wr}, 2'b10);
    tick(); chk("t1_cap", {mbr_ld_mem, mem_rd}, 2'b10);
    tick(); chk("t1_done", {fetch_done, data_done}, 2'b10);
    tick(); chk("t1_idle", busy, 0);
    mem_ready = 0;

    // 2: data read, ready in the second access cycle
    data_req = 1; data_we = 0; data_addr = 8'h3A;
    exp_q.push_back(mk(1, 0, 8'h3A, 0));
    tick(); chk("t2_gnt", {data_gnt, mar_load, mbr_ld_acc}, 3'b110);
    chk("t2_addr", mar_addr, 8'h3A);
    data_req = 0; data_addr = 8'hFF;
    tick(); chk("t2_rd_c2", mem_rd, 1);
    tick(); chk("t2_rd_c3", mem_rd, 1);
    mem_ready = 1;
    tick(); chk("t2_cap", {mbr_ld_mem, mem_rd}, 2'b10);
    mem_ready = 0;
    chk("t2_addr_held", mar_addr, 8'h3A);
    tick(); chk("t2_done", {data_done, fetch_done}, 2'b10);

    // 3: data write, immediate ready
    tick(); chk("t3_idle", busy, 0);
    data_req = 1; data_we = 1; data_addr = 8'h10; mem_ready = 1;
    exp_q.push_back(mk(1, 1, 8'h10, 0));
    tick(); chk("t3_setup", {data_gnt, mar_load, mbr_ld_acc, mbr_ld_mem}, 4'b1110);
    data_req = 0; data_we = 0;
    tick(); chk("t3_wr", {mem_wr, mem_rd, mbr_ld_mem}, 3'b100);
    tick(); chk("t3_done", {data_done, mbr_ld_mem}, 2'b10);
    tick(); chk("t3_idle_after", busy, 0);

    // 4: both held, grants alternate
    fetch_addr = 8'h20; data_addr = 8'h30; data_we = 0;
    exp_q.push_back(mk(0, 0, 8'h20, 0));
    exp_q.push_back(mk(1, 0, 8'h30, 0));
    exp_q.push_back(mk(0, 0, 8'h20, 0));
    exp_q.push_back(mk(1, 0, 8'h30, 0));
    fetch_req = 1; data_req = 1;
    n_done = 0;
    for (int i = 0; i < 60 && n_done < 4; i++) begin
      tick();
      if (fetch_done || data_done) n_done++;
    end
    fetch_req = 0; data_req = 0;
    chk("t4_done_cnt", n_done, 4);
    tick(); chk("t4_idle", busy, 0);
    tick(); chk("t4_no_extra", {busy, fetch_gnt, data_gnt}, 0);

    // 5: read timeout with TIMEOUT=4
    mem_ready = 0; data_req = 1; data_we = 0; data_addr = 8'h44;
    exp_q.push_back(mk(1, 0, 8'h44, 1));
    tick(); chk("t5_gnt", data_gnt, 1);
    data_req = 0;
    n_rd = 0; n_err = 0; n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_rd) n_rd++;
      if (err) n_err++;
      if (fetch_done || data_done) n_done++;
    end
    chk("t5_rd_cycles", n_rd, 4);
    chk("t5_err_cnt", n_err, 1);
    chk("t5_err_last", err, 1);
    chk("t5_no_done", n_done, 0);
    tick(); chk("t5_busy_drop", {busy, err}, 2'b00);

    // 6: reset during access, held request re-granted
    data_req = 1; data_we = 0; data_addr = 8'h77;
    exp_q.push_back(mk(1, 0, 8'h77, 0));
    tick(); chk("t6_gnt", data_gnt, 1);
    tick(); chk("t6_rd", mem_rd, 1);
    rst = 1;
    tick(); chk("t6_rst_outs", {fetch_gnt, data_gnt, fetch_done, data_done, err,
                                busy, mar_load, mbr_ld_acc, mbr_ld_mem, mem_rd, mem_wr}, 0);
    rst = 0; mem_ready = 1;
    exp_q.push_back(mk(1, 0, 8'h77, 0));
    tick(); chk("t6_regnt", {data_gnt, mar_load}, 2'b11);
    data_req = 0;
    tick(); chk("t6_rd2", mem_rd, 1);
    tick(); chk("t6_cap", mbr_ld_mem, 1);
    tick(); chk("t6_done", data_done, 1);
    mem_ready = 0;
    tick(); chk("t6_idle", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("sb_closed", {31'd0, inflight}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
